// File: rtl/load_store_unit_if.sv
// Bundle of core-side request/response and memory-side signals for load_store_unit.
// slave is the LSU's view; master is the view of the core plus data memory.
interface load_store_unit_if;
  logic        req;
  logic        we;
  logic [2:0]  funct3;
  logic [31:0] addr;
  logic [31:0] wdata;
  logic [31:0] rdata;
  logic        done;
  logic        misaligned;
  logic        stall;
  logic [31:0] mem_A;
  logic [31:0] mem_WD;
  logic        mem_WE;
  logic [31:0] mem_RD;

  modport slave (
    input  req, we, funct3, addr, wdata, mem_RD,
    output rdata, done, misaligned, stall, mem_A, mem_WD, mem_WE
  );

  modport master (
    output req, we, funct3, addr, wdata, mem_RD,
    input  rdata, done, misaligned, stall, mem_A, mem_WD, mem_WE
  );
endinterface

// File: rtl/load_store_unit.sv
// RV32I load/store unit: lane-selected loads, read-modify-write sub-word stores,
// and rejection of misaligned or illegal accesses against a word-only memory.
module load_store_unit (
  input  logic              clk,
  input  logic              rst,
  load_store_unit_if.slave  bus
);

  localparam logic [2:0] F3_B  = 3'b000;
  localparam logic [2:0] F3_H  = 3'b001;
  localparam logic [2:0] F3_W  = 3'b010;
  localparam logic [2:0] F3_BU = 3'b100;
  localparam logic [2:0] F3_HU = 3'b101;

  typedef enum logic [1:0] {
    IDLE,
    ACCESS,
    MERGE,
    DONE
  } state_t;

  state_t      state;
  state_t      next_state;

  logic [31:0] addr_q;
  logic [31:0] wd_q;
  logic [31:0] word_q;
  logic [31:0] rdata_q;
  logic [2:0]  f3_q;
  logic        we_q;
  logic        err_q;

  logic        bad;
  logic        accept;
  logic        sub_store;
  logic [7:0]  byte_lane;
  logic [15:0] half_lane;
  logic [31:0] load_val;
  logic [31:0] merged;

  assign accept    = (state == IDLE) && bus.req;
  assign sub_store = we_q && (f3_q != F3_W);

  // Request legality is judged on the live inputs at acceptance.
  always_comb begin
    bad = 1'b0;
    case (bus.funct3)
      F3_B:    bad = 1'b0;
      F3_H:    bad = bus.addr[0];
      F3_W:    bad = |bus.addr[1:0];
      F3_BU:   bad = bus.we;
      F3_HU:   bad = bus.we | bus.addr[0];
      default: bad = 1'b1;
    endcase
  end

  // State register
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      state <= next_state;
    end
  end

  // Next-state logic
  always_comb begin
    next_state = state;
    case (state)
      IDLE: begin
        if (bus.req) begin
          next_state = bad ? DONE : ACCESS;
        end
      end
      ACCESS:  next_state = sub_store ? MERGE : DONE;
      MERGE:   next_state = DONE;
      DONE:    next_state = IDLE;
      default: next_state = IDLE;
    endcase
  end

  // Request capture; memory-side outputs depend only on these copies.
  always_ff @(posedge clk) begin
    if (accept) begin
      addr_q <= bus.addr;
      we_q   <= bus.we;
      f3_q   <= bus.funct3;
      wd_q   <= bus.wdata;
    end
    if ((state == ACCESS) && sub_store) begin
      word_q <= bus.mem_RD;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      err_q   <= 1'b0;
      rdata_q <= '0;
    end else begin
      if (accept) begin
        err_q <= bad;
      end
      if ((state == ACCESS) && !we_q) begin
        rdata_q <= load_val;
      end
    end
  end

  // Load lane selection and extension
  always_comb begin
    byte_lane = bus.mem_RD[{addr_q[1:0], 3'b000} +: 8];
    half_lane = bus.mem_RD[{addr_q[1], 4'b0000} +: 16];
    case (f3_q)
      F3_B:    load_val = {{24{byte_lane[7]}}, byte_lane};
      F3_H:    load_val = {{16{half_lane[15]}}, half_lane};
      F3_BU:   load_val = {24'd0, byte_lane};
      F3_HU:   load_val = {16'd0, half_lane};
      default: load_val = bus.mem_RD;
    endcase
  end

  // Store merge: replace the addressed lane of the word read in ACCESS.
  always_comb begin
    merged = word_q;
    if (f3_q == F3_B) begin
      merged[{addr_q[1:0], 3'b000} +: 8] = wd_q[7:0];
    end else begin
      merged[{addr_q[1], 4'b0000} +: 16] = wd_q[15:0];
    end
  end

  // Output logic; reset suppresses the write in the same cycle it is raised.
  always_comb begin
    bus.mem_A      = {addr_q[31:2], 2'b00};
    bus.mem_WD     = (state == MERGE) ? merged : wd_q;
    bus.mem_WE     = 1'b0;
    bus.done       = 1'b0;
    bus.misaligned = 1'b0;
    bus.stall      = 1'b0;
    bus.rdata      = rdata_q;
    case (state)
      IDLE: begin
        bus.stall = bus.req;
      end
      ACCESS: begin
        bus.stall  = 1'b1;
        bus.mem_WE = we_q && (f3_q == F3_W) && !rst;
      end
      MERGE: begin
        bus.stall  = 1'b1;
        bus.mem_WE = !rst;
      end
      DONE: begin
        bus.done       = 1'b1;
        bus.misaligned = err_q;
      end
      default: begin
        bus.stall = 1'b0;
      end
    endcase
  end

endmodule
